// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: owner codes, FSM states and
// the byte-mask width of the memory port.
package mem_port_arbiter_pkg;

  localparam logic OWN_IF     = 1'b0;
  localparam logic OWN_LS     = 1'b1;
  localparam int   MEM_MASK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_arb_prio_starve.sv
// Fixed-priority (LS first) winner selection with a saturating starvation
// counter that hands the next contested grant to IF after STARVE_MAX losses.
module arb_prio_starve #(
  parameter int STARVE_MAX = 3,
  localparam int CNT_W = $clog2(STARVE_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_valid,
  input  logic ls_valid,
  output logic grant_if,
  output logic grant_ls
);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             starve_hit;

  always_comb begin
    starve_hit = (starve_cnt_q == CNT_W'(STARVE_MAX));
    grant_if   = arb_en && if_valid && (!ls_valid || starve_hit);
    grant_ls   = arb_en && ls_valid && !(if_valid && starve_hit);
    if (grant_if) begin
      starve_cnt_d = '0;
    end else if (grant_ls && if_valid && !starve_hit) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes instruction-fetch and load/store requests onto a single memory
// port with one outstanding transaction (IDLE -> ISSUE -> WAIT).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_resp_valid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic                  ls_we,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [MEM_MASK_W-1:0] ls_wmask,
  output logic                  ls_resp_valid,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [MEM_MASK_W-1:0] mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  state_e                state_q;
  logic                  owner_q;
  logic                  req_valid_q;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [MEM_MASK_W-1:0] wmask_q;

  logic arb_en;
  logic grant_if;
  logic grant_ls;
  logic resp_fire;

  // Arbitration only happens in IDLE; rst forces both readies low immediately.
  assign arb_en = (state_q == ST_IDLE) && !rst;

  arb_prio_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (arb_en),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_if) begin
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            addr_q      <= if_addr;
            wdata_q     <= '0;
            wmask_q     <= '0;
            req_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end else if (grant_ls) begin
            owner_q     <= OWN_LS;
            we_q        <= ls_we;
            addr_q      <= ls_addr;
            wdata_q     <= ls_wdata;
            wmask_q     <= ls_wmask;
            req_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end else begin
            state_q     <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= ST_WAIT;
          end else begin
            state_q     <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        default: begin
          req_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_req_ready  = grant_if;
  assign ls_req_ready  = grant_ls;

  assign mem_req_valid = req_valid_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  // Responses outside WAIT are strays and never reach a requester.
  assign resp_fire     = (state_q == ST_WAIT) && mem_resp_valid && !rst;
  assign if_resp_valid = resp_fire && (owner_q == OWN_IF);
  assign ls_resp_valid = resp_fire && (owner_q == OWN_LS);
  assign if_rdata      = if_resp_valid ? mem_rdata : '0;
  assign ls_rdata      = ls_resp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of
// the arbitration, starvation and one-outstanding-request rules.
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SM = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready, if_resp_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req_valid, ls_req_ready, ls_we, ls_resp_valid;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic [7:0]    ls_wmask;
  logic          mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [7:0]    mem_wmask;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: 0 = free, 1 = request waiting for memory accept, 2 = awaiting response.
  int            phase = 0;
  bit            m_is_ls = 1'b0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [7:0]    m_wmask = '0;
  int            starve = 0;
  bit            after_rst = 1'b0;
  int            grants_if = 0;
  int            grants_ls = 0;

  // mode: 0 random, 1 both requesters + zero-wait, 2 IF only + zero-wait, 3 LS only + zero-wait
  task automatic drive(input int mode, input bit do_rst);
    rst          = do_rst;
    case (mode)
      1:       begin if_req_valid = 1'b1; ls_req_valid = 1'b1; end
      2:       begin if_req_valid = 1'b1; ls_req_valid = 1'b0; end
      3:       begin if_req_valid = 1'b0; ls_req_valid = 1'b1; end
      default: begin
        if_req_valid = ($urandom_range(0, 2) != 0);
        ls_req_valid = ($urandom_range(0, 2) != 0);
      end
    endcase
    if_addr  = (mode == 2) ? 64'h0000_0000_8000_0000 : {$urandom, $urandom};
    ls_we    = $urandom_range(0, 1) == 1;
    ls_addr  = {$urandom, $urandom};
    ls_wdata = {$urandom, $urandom};
    ls_wmask = 8'($urandom);
    mem_rdata = (mode == 2) ? 64'h0000_0000_0010_0093 : {$urandom, $urandom};
    mem_req_ready = (mode != 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    if (phase == 2) begin
      mem_resp_valid = (mode != 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
    end else begin
      mem_resp_valid = ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic check_and_step();
    bit e_if_rdy, e_ls_rdy, e_if_resp, e_ls_resp, hit;
    hit       = (starve == SM);
    e_if_rdy  = !rst && phase == 0 && if_req_valid && (!ls_req_valid || hit);
    e_ls_rdy  = !rst && phase == 0 && ls_req_valid && !(if_req_valid && hit);
    e_if_resp = !rst && phase == 2 && mem_resp_valid && !m_is_ls;
    e_ls_resp = !rst && phase == 2 && mem_resp_valid && m_is_ls;

    chk("if_req_ready", 64'(if_req_ready), 64'(e_if_rdy));
    chk("ls_req_ready", 64'(ls_req_ready), 64'(e_ls_rdy));
    chk("if_resp_valid", 64'(if_resp_valid), 64'(e_if_resp));
    chk("ls_resp_valid", 64'(ls_resp_valid), 64'(e_ls_resp));
    chk("resp_exclusive", 64'(if_resp_valid && ls_resp_valid), 64'd0);
    chk("if_rdata", if_rdata, e_if_resp ? mem_rdata : 64'd0);
    if (!(e_ls_resp && m_we)) begin
      chk("ls_rdata", ls_rdata, e_ls_resp ? mem_rdata : 64'd0);
    end
    chk("mem_req_valid", 64'(mem_req_valid), 64'(phase == 1));
    if (after_rst) begin
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_mem_wdata", mem_wdata, 64'd0);
      chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
    end else if (phase == 1) begin
      chk("mem_we", 64'(mem_we), 64'(m_we));
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wmask", 64'(mem_wmask), 64'(m_wmask));
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end

    after_rst = rst;
    if (rst) begin
      phase  = 0;
      starve = 0;
    end else begin
      case (phase)
        0: begin
          if (e_if_rdy) begin
            m_is_ls = 1'b0; m_we = 1'b0; m_addr = if_addr; m_wmask = 8'h00;
            starve = 0; phase = 1; grants_if++;
          end else if (e_ls_rdy) begin
            m_is_ls = 1'b1; m_we = ls_we; m_addr = ls_addr;
            m_wdata = ls_wdata; m_wmask = ls_wmask;
            if (if_req_valid) starve = (starve + 1 > SM) ? SM : starve + 1;
            phase = 1; grants_ls++;
          end
        end
        1: if (mem_req_ready) phase = 2;
        2: if (mem_resp_valid) phase = 0;
        default: phase = 0;
      endcase
    end
  endtask

  task automatic cycle(input int mode, input bit do_rst);
    @(posedge clk);
    #1;
    drive(mode, do_rst);
    @(negedge clk);
    check_and_step();
  endtask

  initial begin
    rst = 1'b1; if_req_valid = 1'b0; ls_req_valid = 1'b0; if_addr = '0;
    ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;

    cycle(0, 1'b1);
    cycle(0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(2, 1'b0);
    chk("if_only_grants", 64'(grants_if), 64'd3);
    grants_if = 0; grants_ls = 0;
    // One full starvation period: 3 LS grants then 1 IF grant, repeated twice.
    for (int i = 0; i < 24; i++) cycle(1, 1'b0);
    chk("contended_if", 64'(grants_if), 64'd2);
    chk("contended_ls", 64'(grants_ls), 64'd6);
    for (int i = 0; i < 9; i++) cycle(3, 1'b0);
    for (int i = 0; i < 4000; i++) cycle(0, $urandom_range(0, 149) == 0);
    cycle(0, 1'b1);
    cycle(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
